uart_rx_fifo: RTL and testbench

// Receive buffer directly downstream of the UART receiver. Accepts assembled characters over a valid/ready

---
 rtl/uart_rx_fifo.sv | 79 +++++++
 tb/tb_uart_rx_fifo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer with fill-level and character-timeout interrupts
//   clk_i, rst_i (sync, active high), clr_i (sync flush)
//   data_i/valid_i/ready_o : write side from the UART receiver
//   data_o/valid_o/ready_i : read side to the register file
//   elements_o             : occupancy 0..DEPTH
//   trig_lvl_i, irq_fill_o : fill trigger (1, 4, 8, DEPTH-2) and its level interrupt
//   tout_limit_i, irq_tout_o : idle-cycle limit (0 disables) and sticky timeout flag
module uart_rx_fifo #(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 8,
    parameter int TOUT_W     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_i,
    input  logic [DATA_WIDTH-1:0]      data_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [DATA_WIDTH-1:0]      data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic [$clog2(DEPTH):0]     elements_o,
    input  logic [1:0]                 trig_lvl_i,
    input  logic [TOUT_W-1:0]          tout_limit_i,
    output logic                       irq_fill_o,
    output logic                       irq_tout_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]           cnt_q, cnt_d, lvl;
    logic [TOUT_W-1:0]     tcnt_q, tcnt_d;
    logic                  tout_q, tout_d, push, pop, idle;

    assign ready_o    = cnt_q != (AW+1)'(DEPTH);
    assign valid_o    = cnt_q != '0;
    assign push       = valid_i & ready_o;
    assign pop        = valid_o & ready_i;
    assign data_o     = mem_q[rd_q];
    assign elements_o = cnt_q;
    assign irq_tout_o = tout_q;
    assign lvl        = trig_lvl_i == 2'd0 ? (AW+1)'(1) :
                        trig_lvl_i == 2'd1 ? (AW+1)'(4) :
                        trig_lvl_i == 2'd2 ? (AW+1)'(8) : (AW+1)'(DEPTH-2);
    assign irq_fill_o = cnt_q >= lvl;
    // counter only runs while bytes sit untouched in a non-empty FIFO
    assign idle       = !(clr_i | push | pop) && valid_o;

    always_comb begin
        rd_d   = clr_i ? '0 : rd_q + AW'(pop);
        wr_d   = clr_i ? '0 : wr_q + AW'(push);
        cnt_d  = clr_i ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        tcnt_d = !idle ? '0 : (&tcnt_q ? tcnt_q : tcnt_q + 1'b1);
        // flag rises on the edge that completes tout_limit_i idle cycles
        tout_d = (clr_i | pop) ? 1'b0 :
                 (idle && tout_limit_i != '0 && tcnt_q == tout_limit_i - 1'b1) ? 1'b1 : tout_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q   <= '0;
            wr_q   <= '0;
            cnt_q  <= '0;
            tcnt_q <= '0;
            tout_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            wr_q   <= wr_d;
            cnt_q  <= cnt_d;
            tcnt_q <= tcnt_d;
            tout_q <= tout_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push && !clr_i && !rst_i) mem_q[wr_q] <= data_i;
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
    logic        clk_i = 1'b0, rst_i = 1'b0, clr_i = 1'b0;
    logic [7:0]  data_i = '0, data_o;
    logic        valid_i = 1'b0, ready_o, valid_o, ready_i = 1'b0;
    logic [4:0]  elements_o;
    logic [1:0]  trig_lvl_i = 2'd0;
    logic [15:0] tout_limit_i = '0;
    logic        irq_fill_o, irq_tout_o;
    int          total = 0, bad = 0;

    uart_rx_fifo #(.DEPTH(16), .DATA_WIDTH(8), .TOUT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clr_i(clr_i), .data_i(data_i), .valid_i(valid_i),
        .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .elements_o(elements_o), .trig_lvl_i(trig_lvl_i), .tout_limit_i(tout_limit_i),
        .irq_fill_o(irq_fill_o), .irq_tout_o(irq_tout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic push_b(input logic [7:0] d);
        data_i = d; valid_i = 1'b1; tick(); valid_i = 1'b0;
    endtask

    task automatic pop_b(output logic [7:0] d, output logic v);
        d = data_o; v = valid_o; ready_i = 1'b1; tick(); ready_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        total++; if (elements_o !== 5'd0) begin bad++; $display("FAIL rst_elements got=%0d exp=0", elements_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", ready_o); end
        total++; if ({irq_fill_o, irq_tout_o} !== 2'b00) begin bad++; $display("FAIL rst_irqs got=%b exp=00", {irq_fill_o, irq_tout_o}); end
        push_b(8'hA5);
        total++; if ({valid_o, data_o, elements_o} !== {1'b1, 8'hA5, 5'd1}) begin bad++; $display("FAIL first_push got v=%b d=%h n=%0d exp v=1 d=a5 n=1", valid_o, data_o, elements_o); end
    endtask

    task automatic test_fill;
        logic [7:0] d; logic v;
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_b(8'(i));
            if (i == 14) begin total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL ready_at15 got=%b exp=1", ready_o); end end
        end
        total++; if ({ready_o, elements_o} !== {1'b0, 5'd16}) begin bad++; $display("FAIL full got r=%b n=%0d exp r=0 n=16", ready_o, elements_o); end
        data_i = 8'h55; valid_i = 1'b1; tick(3); valid_i = 1'b0;
        total++; if (elements_o !== 5'd16) begin bad++; $display("FAIL blocked_push got=%0d exp=16", elements_o); end
        for (int i = 0; i < 16; i++) begin
            pop_b(d, v);
            total++; if ({v, d} !== {1'b1, 8'(i)}) begin bad++; $display("FAIL fill_order[%0d] got v=%b d=%h exp v=1 d=%h", i, v, d, 8'(i)); end
        end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL drained got=%b exp=0", valid_o); end
    endtask

    task automatic test_wrap;
        logic [7:0] d; logic v;
        for (int i = 0; i < 10; i++) push_b(8'h10 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            pop_b(d, v);
            total++; if (d !== 8'h10 + 8'(i)) begin bad++; $display("FAIL wrap_a[%0d] got=%h exp=%h", i, d, 8'h10 + 8'(i)); end
        end
        for (int i = 0; i < 16; i++) push_b(8'h20 + 8'(i));
        total++; if ({ready_o, elements_o} !== {1'b0, 5'd16}) begin bad++; $display("FAIL wrap_full got r=%b n=%0d exp r=0 n=16", ready_o, elements_o); end
        for (int i = 0; i < 16; i++) begin
            pop_b(d, v);
            total++; if ({v, d} !== {1'b1, 8'h20 + 8'(i)}) begin bad++; $display("FAIL wrap_b[%0d] got v=%b d=%h exp v=1 d=%h", i, v, d, 8'h20 + 8'(i)); end
        end
        total++; if (elements_o !== 5'd0) begin bad++; $display("FAIL wrap_empty got=%0d exp=0", elements_o); end
    endtask

    task automatic test_concurrent;
        logic [7:0] d; logic v;
        logic [7:0] exp_q [5] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h77};
        for (int i = 0; i < 5; i++) push_b(8'h40 + 8'(i));
        data_i = 8'h77; valid_i = 1'b1; ready_i = 1'b1; tick(); valid_i = 1'b0; ready_i = 1'b0;
        total++; if ({elements_o, data_o} !== {5'd5, 8'h41}) begin bad++; $display("FAIL concurrent got n=%0d d=%h exp n=5 d=41", elements_o, data_o); end
        for (int i = 0; i < 5; i++) begin
            pop_b(d, v);
            total++; if (d !== exp_q[i]) begin bad++; $display("FAIL concurrent_order[%0d] got=%h exp=%h", i, d, exp_q[i]); end
        end
    endtask

    task automatic test_trigger;
        trig_lvl_i = 2'b01;
        for (int i = 0; i < 3; i++) push_b(8'(i));
        total++; if (irq_fill_o !== 1'b0) begin bad++; $display("FAIL trig4_at3 got=%b exp=0", irq_fill_o); end
        push_b(8'h03);
        total++; if (irq_fill_o !== 1'b1) begin bad++; $display("FAIL trig4_at4 got=%b exp=1", irq_fill_o); end
        trig_lvl_i = 2'b11; #1;
        total++; if (irq_fill_o !== 1'b0) begin bad++; $display("FAIL trig14_at4 got=%b exp=0", irq_fill_o); end
        for (int i = 4; i < 13; i++) push_b(8'(i));
        total++; if (irq_fill_o !== 1'b0) begin bad++; $display("FAIL trig14_at13 got=%b exp=0", irq_fill_o); end
        push_b(8'h0D);
        total++; if ({elements_o, irq_fill_o} !== {5'd14, 1'b1}) begin bad++; $display("FAIL trig14_at14 got n=%0d i=%b exp n=14 i=1", elements_o, irq_fill_o); end
        trig_lvl_i = 2'b00;
        clr_i = 1'b1; data_i = 8'hEE; valid_i = 1'b1; tick(); clr_i = 1'b0; valid_i = 1'b0;
        total++; if ({elements_o, valid_o, irq_fill_o} !== {5'd0, 1'b0, 1'b0}) begin bad++; $display("FAIL clr_flush got n=%0d v=%b i=%b exp n=0 v=0 i=0", elements_o, valid_o, irq_fill_o); end
    endtask

    task automatic test_timeout;
        logic [7:0] d; logic v;
        tout_limit_i = 16'd100;
        push_b(8'h61); tick(99);
        total++; if (irq_tout_o !== 1'b0) begin bad++; $display("FAIL tout_99 got=%b exp=0", irq_tout_o); end
        tick();
        total++; if (irq_tout_o !== 1'b1) begin bad++; $display("FAIL tout_100 got=%b exp=1", irq_tout_o); end
        push_b(8'h62);
        total++; if (irq_tout_o !== 1'b1) begin bad++; $display("FAIL tout_push_keeps got=%b exp=1", irq_tout_o); end
        pop_b(d, v);
        total++; if ({irq_tout_o, elements_o} !== {1'b0, 5'd1}) begin bad++; $display("FAIL tout_pop_clears got t=%b n=%0d exp t=0 n=1", irq_tout_o, elements_o); end
        tick(50); push_b(8'h63); tick(99);
        total++; if (irq_tout_o !== 1'b0) begin bad++; $display("FAIL tout_restart_99 got=%b exp=0", irq_tout_o); end
        tick();
        total++; if (irq_tout_o !== 1'b1) begin bad++; $display("FAIL tout_restart_100 got=%b exp=1", irq_tout_o); end
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        total++; if (irq_tout_o !== 1'b0) begin bad++; $display("FAIL tout_clr got=%b exp=0", irq_tout_o); end
        push_b(8'h64); tick(60);
        clr_i = 1'b1; tick(); clr_i = 1'b0; tick(100);
        total++; if (irq_tout_o !== 1'b0) begin bad++; $display("FAIL tout_clr_mid got=%b exp=0", irq_tout_o); end
        tout_limit_i = 16'd0;
        push_b(8'h65); tick(200);
        total++; if (irq_tout_o !== 1'b0) begin bad++; $display("FAIL tout_disabled got=%b exp=0", irq_tout_o); end
        tout_limit_i = 16'd3;
        push_b(8'h66); push_b(8'h67); tick(2);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        total++; if ({elements_o, valid_o, ready_o, irq_fill_o, irq_tout_o} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin bad++; $display("FAIL rst_mid_fill got n=%0d v=%b r=%b f=%b t=%b exp n=0 v=0 r=1 f=0 t=0", elements_o, valid_o, ready_o, irq_fill_o, irq_tout_o); end
        tick(5);
        total++; if (irq_tout_o !== 1'b0) begin bad++; $display("FAIL rst_tout_idle got=%b exp=0", irq_tout_o); end
    endtask

    initial begin
        tick();
        test_reset();
        test_fill();
        test_wrap();
        test_concurrent();
        test_trigger();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
